// File: rtl/buzzer_tone_pkg.sv
// Shared definitions for the buzzer tone generator: register map addresses,
// CTRL/STATUS bit positions and the playback state type.
package buzzer_tone_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_HALF   = 2'd1;
  localparam logic [1:0] ADDR_DUR    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_INVERT  = 2;
  localparam int CTRL_IE      = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/buzzer_tone_tick.sv
// Duration prescaler: counts 0..PRESCALE-1 while enabled and raises a
// one-cycle tick on the last count, where it wraps back to 0.
module buzzer_tone_tick #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_count;

  assign o_tick = i_enable && (r_count == LAST);

  // Free-running divider, held at zero while cleared so each start is aligned
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (r_count == LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + PW'(1);
      end
    end
  end

endmodule

// File: rtl/buzzer_tone.sv
// Avalon-MM buzzer tone generator: square wave of period 2*(HALF_PERIOD+1)
// cycles on out_port, either continuous or for a programmed number of
// prescaler ticks. Optional completion interrupt enabled by defining
// BUZZER_TONE_IRQ_EN (adds the irq port and the CTRL.IE bit).
module buzzer_tone
  import buzzer_tone_pkg::*;
#(
  parameter int CNT_W    = 24,
  parameter int DUR_W    = 16,
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port
`ifdef BUZZER_TONE_IRQ_EN
  ,
  output logic        irq
`endif
);

  // Programmed registers
  logic             r_en;
  logic             r_oneshot;
  logic             r_invert;
  logic [CNT_W-1:0] r_halfPeriod;
  logic [DUR_W-1:0] r_duration;
`ifdef BUZZER_TONE_IRQ_EN
  logic             r_ie;
  logic             r_irq;
`endif

  // Playback state
  state_t           r_state;
  logic [CNT_W-1:0] r_toneCnt;
  logic             r_tone;
  logic [DUR_W-1:0] r_remaining;
  logic             r_done;

  logic w_write;
  logic w_ctrlWr;
  logic w_halfWr;
  logic w_durWr;
  logic w_statWr;
  logic w_playing;
  logic w_start;
  logic w_halfZero;
  logic w_tick;
  logic w_tickEn;
  logic w_tickClr;
  logic w_finish;
  logic w_unused;

  assign w_write    = chipselect && !write_n;
  assign w_ctrlWr   = w_write && (address == ADDR_CTRL);
  assign w_halfWr   = w_write && (address == ADDR_HALF);
  assign w_durWr    = w_write && (address == ADDR_DUR);
  assign w_statWr   = w_write && (address == ADDR_STATUS);
  assign w_playing  = (r_state == ST_PLAY);
  assign w_start    = w_ctrlWr && writedata[CTRL_EN] && (r_halfPeriod != '0);
  assign w_halfZero = (writedata[CNT_W-1:0] == '0);
  assign w_tickEn   = w_playing && r_oneshot;
  assign w_tickClr  = !w_playing || w_start;
  assign w_finish   = w_playing && r_oneshot && w_tick && (r_remaining <= DUR_W'(1));

  // Upper write-data bits beyond the register widths are deliberately ignored
  assign w_unused = ^writedata;

  buzzer_tone_tick #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_tickClr),
    .i_enable (w_tickEn),
    .o_tick   (w_tick)
  );

  // Host-visible configuration registers, written over the slave port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en         <= 1'b0;
      r_oneshot    <= 1'b0;
      r_invert     <= 1'b0;
      r_halfPeriod <= '0;
      r_duration   <= '0;
`ifdef BUZZER_TONE_IRQ_EN
      r_ie         <= 1'b0;
`endif
    end else begin
      if (w_ctrlWr) begin
        r_en      <= writedata[CTRL_EN];
        r_oneshot <= writedata[CTRL_ONESHOT];
        r_invert  <= writedata[CTRL_INVERT];
`ifdef BUZZER_TONE_IRQ_EN
        r_ie      <= writedata[CTRL_IE];
`endif
      end
      if (w_halfWr) begin
        r_halfPeriod <= writedata[CNT_W-1:0];
      end
      if (w_durWr) begin
        r_duration <= writedata[DUR_W-1:0];
      end
    end
  end

  // Playback FSM: host commands outrank natural completion in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_toneCnt   <= '0;
      r_tone      <= 1'b0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_statWr && writedata[STAT_DONE]) begin
        r_done <= 1'b0;
      end
      if (w_start) begin
        r_state     <= ST_PLAY;
        r_toneCnt   <= '0;
        r_tone      <= 1'b0;
        r_remaining <= r_duration;
      end else if (w_ctrlWr || (w_playing && w_halfWr && w_halfZero)) begin
        r_state   <= ST_IDLE;
        r_toneCnt <= '0;
        r_tone    <= 1'b0;
      end else if (w_playing) begin
        if (w_finish) begin
          r_state   <= ST_IDLE;
          r_toneCnt <= '0;
          r_tone    <= 1'b0;
          r_done    <= 1'b1;
        end else begin
          if (r_toneCnt >= r_halfPeriod) begin
            r_tone    <= ~r_tone;
            r_toneCnt <= '0;
          end else begin
            r_toneCnt <= r_toneCnt + CNT_W'(1);
          end
          if (w_tick) begin
            r_remaining <= r_remaining - DUR_W'(1);
          end
        end
      end else begin
        r_toneCnt <= '0;
        r_tone    <= 1'b0;
      end
    end
  end

`ifdef BUZZER_TONE_IRQ_EN
  // Interrupt is a registered copy of the enabled completion flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_done && r_ie;
    end
  end

  assign irq = r_irq;
`endif

  assign out_port = r_tone ^ r_invert;

  // Zero-wait-state read mux; DURATION shows the live countdown while busy
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN]      = r_en;
        readdata[CTRL_ONESHOT] = r_oneshot;
        readdata[CTRL_INVERT]  = r_invert;
`ifdef BUZZER_TONE_IRQ_EN
        readdata[CTRL_IE]      = r_ie;
`endif
      end
      ADDR_HALF: begin
        readdata = 32'(r_halfPeriod);
      end
      ADDR_DUR: begin
        readdata = w_playing ? 32'(r_remaining) : 32'(r_duration);
      end
      default: begin
        readdata[STAT_BUSY] = w_playing;
        readdata[STAT_DONE] = r_done;
      end
    endcase
  end

endmodule

// File: doc/buzzer_tone.md
BUZZER_TONE -- requirements
Module: buzzer_tone

Interface
REQ-001 Parameter CNT_W, default 24: width of the half-period register and the tone counter.
REQ-002 Parameter DUR_W, default 16: width of the duration register and the remaining-duration counter.
REQ-003 Parameter PRESCALE, default 50000: clk cycles per duration tick (1 ms at 50 MHz); legal range 1 or more.
REQ-004 Port: clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port: address, input, 2, Avalon-MM register select.
REQ-007 Port: chipselect, input, 1, Avalon-MM slave select.
REQ-008 Port: write_n, input, 1, active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-009 Port: writedata, input, 32, write data.
REQ-010 Port: readdata, output, 32, combinational read data (zero wait states), selected by address.
REQ-011 Port: out_port, output, 1, buzzer drive.
REQ-012 Port: irq, output, 1, completion interrupt; present only with BUZZER_TONE_IRQ_EN defined.

Function
REQ-013 The register map SHALL be as follows; unused bits read 0 and ignore writes.
- Address 0, CTRL: bit0 EN, bit1 ONESHOT, bit2 INVERT, bit3 IE.
- Address 1, HALF_PERIOD: CNT_W bits.
- Address 2, DURATION: DUR_W bits.
- Address 3, STATUS: bit0 BUSY (read-only), bit1 DONE (sticky; writing 1 clears it).
REQ-014 The FSM SHALL have two states, IDLE and PLAY; BUSY=1 exactly in PLAY.
REQ-015 IDLE to PLAY: on a CTRL write with EN=1 while HALF_PERIOD is nonzero.
- Takes effect the cycle after the write.
- Tone counter, prescaler and tone level clear to 0.
- The remaining-duration counter loads DURATION.
REQ-016 A CTRL write with EN=1 in PLAY SHALL restart, with the same loads as REQ-015.
REQ-017 A CTRL write with EN=0 SHALL return the FSM to IDLE the next cycle; DONE is not set.
REQ-018 In PLAY, the tone counter increments every cycle.
- When the counter is >= HALF_PERIOD, the tone toggles and the counter reloads to 0.
- The square-wave period is therefore 2*(HALF_PERIOD+1) cycles.
REQ-019 A HALF_PERIOD write during PLAY SHALL take effect at the counter's next comparison, without a restart.
REQ-020 Writing HALF_PERIOD=0 during PLAY SHALL force IDLE the next cycle; DONE is not set.
REQ-021 In ONESHOT, the prescaler counts 0..PRESCALE-1 and decrements the remaining count at each wrap.
- A wrap with the remaining count at 0 or 1 returns the FSM to IDLE and sets DONE.
- DURATION=0 therefore gives exactly PRESCALE cycles of tone.
REQ-022 With ONESHOT=0, the block SHALL play until it is stopped; the duration logic is inert.
REQ-023 out_port SHALL equal the registered tone XOR INVERT; the tone is held at 0 in IDLE.
REQ-024 A read at address 2 SHALL return the remaining count while BUSY, and the programmed DURATION otherwise.
REQ-025 If DONE is set and W1C-cleared in the same cycle, the set SHALL win.
REQ-026 Writes to unmapped bits, and reads, SHALL have no side effects.

Reset
REQ-027 Assertion of reset_n=0 SHALL immediately clear all state, including mid-PLAY, with no glitch beyond the asynchronous transition:
- CTRL=0, HALF_PERIOD=0, DURATION=0;
- DONE=0, FSM=IDLE;
- all counters=0;
- out_port=0, irq=0.

Configuration
REQ-028 With BUZZER_TONE_IRQ_EN defined, irq SHALL equal the registered value of DONE AND IE.
REQ-029 Without BUZZER_TONE_IRQ_EN, the irq port and the IE storage SHALL be absent, and CTRL bit3 reads 0.

Structure
REQ-030 The shared package buzzer_tone_pkg SHALL hold:
- the register address constants;
- the CTRL and STATUS bit indices;
- the IDLE/PLAY state typedef.
REQ-031 The prescaler SHALL be the sub-module buzzer_tone_tick, with a clear input and a one-cycle tick output; all other logic is in buzzer_tone.

Verification
REQ-032 Reset release, then HALF_PERIOD=4 and CTRL=0x1 -> out_port toggles every 5 cycles (period 10), with BUSY=1.
REQ-033 PRESCALE=10 build, HALF_PERIOD=2, DURATION=3, CTRL=0x3 -> exactly 30 cycles in PLAY, then IDLE, out_port=0, DONE=1; STATUS write of 0x2 -> DONE=0.
REQ-034 CTRL=0x5 (INVERT) with HALF_PERIOD=0 -> stays IDLE with out_port=1; then HALF_PERIOD=3 and CTRL=0x5 -> toggling starts from a level of 1.
REQ-035 During a one-shot, HALF_PERIOD 8 -> 2 when the counter is at 5 -> toggle on the next cycle, then period 6; an EN=0 write -> IDLE, DONE stays 0.
REQ-036 reset_n pulsed low mid-PLAY -> all outputs and registers are 0 immediately; with IRQ_EN, a one-shot with IE=1 -> irq rises one cycle after DONE sets.
